// File: rtl/ann_stream_loader.sv
// Streams the image and per-layer weights into the ANN buffers, runs the core, and shows the result.
// Optional watchdog on LOAD/WAIT is enabled by defining ANN_LOADER_TIMEOUT_EN.
module ann_stream_loader #(
  parameter int DATA_W         = 16,
  parameter int IMAGE_SIZE     = 64,
  parameter int LAYER_SIZE     = 16,
  parameter int NUM_LAYERS     = 2,
  parameter int ADDR_W         = 10,
  parameter int SEL_W          = 2,
  parameter int BUF_AW         = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start_detecting,
  input  logic [ADDR_W-1:0] image_address,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [SEL_W-1:0]  coef_select,
  input  logic              bus_valid,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_last,
  output logic              bus_ready,
  output logic              buf_we,
  output logic [SEL_W-1:0]  buf_sel,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              ann_start,
  input  logic              ann_done,
  input  logic [3:0]        ann_class,
  output logic [7:0]        seven_seg,
  output logic              done_processing,
  output logic              busy,
  output logic              error
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // REQ     | one-cycle bus request for the current set
  // LOAD    | accepting words of the current set
  // RUN     | one-cycle start pulse to the ANN core
  // WAIT    | waiting for the ANN result
  // DONE    | result shown, done_processing held
  // ERROR   | framing/timeout error, "E" shown
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_RUN, S_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam int N_IMG = IMAGE_SIZE;
  localparam int N_L1  = LAYER_SIZE * IMAGE_SIZE;
  localparam int N_LN  = LAYER_SIZE * LAYER_SIZE;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  set_q;
  logic [BUF_AW-1:0] cnt_q;
  logic [BUF_AW-1:0] last_idx;
  logic              idle_like, start_ok, accept, at_last;
  logic              set_done, frame_err, final_set, timeout;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start_ok  = idle_like && start_detecting;
  assign accept    = (state == S_LOAD) && bus_valid;
  assign at_last   = (cnt_q == last_idx);
  assign set_done  = accept && bus_last && at_last;
  assign frame_err = accept && (bus_last != at_last);
  assign final_set = (set_q == SEL_W'(NUM_LAYERS));

  always_comb begin
    last_idx = BUF_AW'(N_LN - 1);
    if (set_q == '0)
      last_idx = BUF_AW'(N_IMG - 1);
    else if (set_q == SEL_W'(1))
      last_idx = BUF_AW'(N_L1 - 1);
  end

`ifdef ANN_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Down-counter reloaded on any state change or accepted word; expires at zero.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      wd_q <= '0;
    else if ((state_nxt != state) || accept)
      wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
    else if (((state == S_LOAD) || (state == S_WAIT)) && (wd_q != '0))
      wd_q <= wd_q - 1'b1;
  end

  assign timeout = ((state == S_LOAD) || (state == S_WAIT)) && (wd_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start_detecting) state_nxt = S_REQ;
      S_REQ:
        state_nxt = S_LOAD;
      S_LOAD:
        if (frame_err)     state_nxt = S_ERROR;
        else if (set_done) state_nxt = final_set ? S_RUN : S_REQ;
        else if (timeout)  state_nxt = S_ERROR;
      S_RUN:
        state_nxt = S_WAIT;
      S_WAIT:
        if (ann_done)     state_nxt = S_DONE;
        else if (timeout) state_nxt = S_ERROR;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req         = (state == S_REQ);
    bus_ready       = (state == S_LOAD);
    ann_start       = (state == S_RUN);
    done_processing = (state == S_DONE);
    error           = (state == S_ERROR);
    busy            = !idle_like;
    coef_select     = set_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      set_q    <= '0;
      cnt_q    <= '0;
      bus_addr <= '0;
    end else begin
      if (start_ok) begin
        set_q    <= '0;
        bus_addr <= image_address;
      end else if (set_done && !final_set) begin
        set_q <= set_q + 1'b1;
      end
      if (start_ok || (state == S_REQ))
        cnt_q <= '0;
      else if (accept)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // One-cycle write pipeline; a word that breaks framing is dropped.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      buf_we    <= 1'b0;
      buf_sel   <= '0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else begin
      buf_we <= accept && !frame_err;
      if (accept) begin
        buf_sel   <= set_q;
        buf_addr  <= cnt_q;
        buf_wdata <= bus_data;
      end
    end
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] c);
    case (c)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      seven_seg <= 8'hFF;
    else if ((state == S_WAIT) && ann_done)
      seven_seg <= seg_decode(ann_class);
    else if (state_nxt == S_ERROR && state != S_ERROR)
      seven_seg <= 8'h86;
  end

endmodule

// File: tb/tb_ann_stream_loader.sv
// Directed bench for ann_stream_loader with IMAGE_SIZE=4, LAYER_SIZE=2, NUM_LAYERS=2 (sets of 4/8/4 words).
// Watchdog scenario runs only when ANN_LOADER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_ann_stream_loader;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start_detecting = 1'b0;
  logic [9:0]  image_address = '0;
  logic        bus_req;
  logic [9:0]  bus_addr;
  logic [1:0]  coef_select;
  logic        bus_valid = 1'b0;
  logic [15:0] bus_data = '0;
  logic        bus_last = 1'b0;
  logic        bus_ready;
  logic        buf_we;
  logic [1:0]  buf_sel;
  logic [3:0]  buf_addr;
  logic [15:0] buf_wdata;
  logic        ann_start;
  logic        ann_done = 1'b0;
  logic [3:0]  ann_class = '0;
  logic [7:0]  seven_seg;
  logic        done_processing;
  logic        busy;
  logic        error;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] wr_log[$];
  logic [1:0]  req_log[$];
  int          n_start = 0;

  always #5 clk = ~clk;

  ann_stream_loader #(
    .DATA_W(16), .IMAGE_SIZE(4), .LAYER_SIZE(2), .NUM_LAYERS(2),
    .ADDR_W(10), .SEL_W(2), .BUF_AW(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .n_reset(n_reset), .start_detecting(start_detecting),
    .image_address(image_address), .bus_req(bus_req), .bus_addr(bus_addr),
    .coef_select(coef_select), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_last(bus_last), .bus_ready(bus_ready), .buf_we(buf_we),
    .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .ann_start(ann_start), .ann_done(ann_done), .ann_class(ann_class),
    .seven_seg(seven_seg), .done_processing(done_processing),
    .busy(busy), .error(error)
  );

  always @(negedge clk) begin
    if (buf_we)    wr_log.push_back({10'd0, buf_sel, buf_addr, buf_wdata});
    if (bus_req)   req_log.push_back(coef_select);
    if (ann_start) n_start++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    req_log.delete();
    n_start = 0;
  endtask

  task automatic start_run(input logic [9:0] addr);
    @(negedge clk);
    start_detecting = 1'b1;
    image_address   = addr;
    @(negedge clk);
    start_detecting = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    bus_valid = 1'b1;
    bus_data  = d;
    bus_last  = last;
    while (!bus_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
  endtask

  task automatic send_set(input int s, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) @(negedge clk);
      send(16'(16'h1000 * (s + 1) + i), i == n - 1);
    end
  endtask

  task automatic give_result(input logic [3:0] c);
    repeat (3) @(negedge clk);
    ann_class = c;
    ann_done  = 1'b1;
    @(negedge clk);
    ann_done  = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done_processing || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("end_timeout", 32'd0, 32'd1);
  endtask

  // Expected stream for a full load: image (sel 0), layer 0 (sel 1), layer 1 (sel 2).
  task automatic check_full_log();
    logic [31:0] exp;
    int s, a;
    chk("wr_count", wr_log.size(), 16);
    chk("req_count", req_log.size(), 3);
    for (int i = 0; i < 3 && i < req_log.size(); i++)
      chk("req_sel", req_log[i], i);
    for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
      s = (i < 4) ? 0 : (i < 12) ? 1 : 2;
      a = (s == 0) ? i : (s == 1) ? i - 4 : i - 12;
      exp = {10'd0, 2'(s), 4'(a), 16'(16'h1000 * (s + 1) + a)};
      chk("wr_entry", wr_log[i], exp);
    end
    chk("ann_start_count", n_start, 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("rst_seg", seven_seg, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_done", done_processing, 0);
    chk("rst_ready", bus_ready, 0);

    // Nominal full load, class 3
    clear_logs();
    start_run(10'h155);
    send_set(0, 4, 0);
    send_set(1, 8, 0);
    send_set(2, 4, 0);
    give_result(4'd3);
    wait_end();
    check_full_log();
    chk("nom_seg", seven_seg, 8'hB0);
    chk("nom_done", done_processing, 1);
    chk("nom_busy", busy, 0);
    chk("nom_addr", bus_addr, 10'h155);

    // Early bus_last on image word 2
    clear_logs();
    start_run(10'h0AA);
    chk("restart_done_clr", done_processing, 0);
    send(16'h1000, 1'b0);
    send(16'h1001, 1'b0);
    send(16'h1002, 1'b1);
    wait_end();
    repeat (2) @(negedge clk);
    chk("early_err", error, 1);
    chk("early_seg", seven_seg, 8'h86);
    chk("early_wr", wr_log.size(), 2);
    chk("early_busy", busy, 0);

    // Missing bus_last on the final image word
    clear_logs();
    start_run(10'h001);
    chk("restart_err_clr", error, 0);
    for (int i = 0; i < 4; i++) send(16'(16'h1000 + i), 1'b0);
    wait_end();
    repeat (2) @(negedge clk);
    chk("nolast_err", error, 1);
    chk("nolast_wr", wr_log.size(), 3);

    // Stalled layer-0 stream; stray ann_done and start while busy are ignored
    clear_logs();
    start_run(10'h200);
    ann_class = 4'd1;
    ann_done  = 1'b1;
    @(negedge clk);
    ann_done  = 1'b0;
    send_set(0, 4, 0);
    start_detecting = 1'b1;
    send_set(1, 8, 1);
    start_detecting = 1'b0;
    send_set(2, 4, 0);
    chk("stray_done_seg", seven_seg, 8'h86);
    give_result(4'd7);
    wait_end();
    check_full_log();
    chk("stall_seg", seven_seg, 8'hF8);
    chk("stall_addr", bus_addr, 10'h200);

    // Reset mid layer-0 load, then full reload with class 12
    clear_logs();
    start_run(10'h033);
    send_set(0, 4, 0);
    send(16'h2000, 1'b0);
    send(16'h2001, 1'b0);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_seg", seven_seg, 8'hFF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus_ready, 0);
    chk("mid_rst_we", buf_we, 0);
    chk("mid_rst_sel", coef_select, 0);
    chk("mid_rst_addr", bus_addr, 0);
    @(negedge clk);
    n_reset = 1'b1;
    clear_logs();
    start_run(10'h034);
    send_set(0, 4, 0);
    send_set(1, 8, 0);
    send_set(2, 4, 0);
    give_result(4'd12);
    wait_end();
    check_full_log();
    chk("dash_seg", seven_seg, 8'hBF);
    chk("dash_done", done_processing, 1);

`ifdef ANN_LOADER_TIMEOUT_EN
    // Watchdog: withhold ann_done; 16 cycles in WAIT then ERROR
    clear_logs();
    start_run(10'h077);
    send_set(0, 4, 0);
    send_set(1, 8, 0);
    send_set(2, 4, 0);
    repeat (16) @(posedge clk);
    #1;
    chk("wd_not_yet", error, 0);
    chk("wd_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("wd_err", error, 1);
    chk("wd_seg", seven_seg, 8'h86);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ann_stream_loader.md
Name: ann_stream_loader

Overview:
- Parametrised successor to the ANN top-level load/run sequencing.
- Fetches the image and the coefficients for every layer from the verification bus as word-serial valid/ready streams, and writes them into the ANN buffers.
- Starts the ANN core, waits for its result, then drives a 7-segment display and done_processing.
- Supports any layer count, data width and buffer depth; detects framing errors.

Parameters:
- DATA_W, 16, width of image and coefficient words.
- IMAGE_SIZE, 64, number of image words.
- LAYER_SIZE, 16, neurons per layer.
- NUM_LAYERS, 2, number of weight layers; valid range 1..(2**SEL_W)-1.
- ADDR_W, 10, width of image_address.
- SEL_W, 2, width of coef_select.
- BUF_AW, 10, buffer address width; must satisfy 2**BUF_AW >= LAYER_SIZE*IMAGE_SIZE.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk, in, 1, clock.
- n_reset, in, 1, asynchronous, active-low reset.
- start_detecting, in, 1, level; sampled at each posedge.
- image_address, in, ADDR_W, image location passed to the bus.
- bus_req, out, 1, one-cycle request pulse per data set.
- bus_addr, out, ADDR_W, copy of image_address latched on start.
- coef_select, out, SEL_W, 0 = image, k+1 = layer k weights.
- bus_valid, in, 1, word valid.
- bus_data, in, DATA_W, word.
- bus_last, in, 1, marks the final word of a set.
- bus_ready, out, 1, loader accepts words.
- buf_we, out, 1, buffer write strobe.
- buf_sel, out, SEL_W, target buffer (same encoding as coef_select).
- buf_addr, out, BUF_AW, word index within the set.
- buf_wdata, out, DATA_W, word to write.
- ann_start, out, 1, one-cycle pulse to the ANN core.
- ann_done, in, 1, ANN result valid pulse.
- ann_class, in, 4, classification result.
- seven_seg, out, 8, active-low {dp,g,f,e,d,c,b,a}.
- done_processing, out, 1, result valid; held high.
- busy, out, 1, high in any state except IDLE, DONE, ERROR.
- error, out, 1, framing or timeout error; held high.

Behaviour:
- Reset values: all outputs 0, except seven_seg = 8'hFF (blank). State = IDLE; all counters 0.
- Word counts per set:
  - set 0 (image): IMAGE_SIZE.
  - set 1: LAYER_SIZE*IMAGE_SIZE.
  - sets 2..NUM_LAYERS: LAYER_SIZE*LAYER_SIZE.
- State machine:
  - IDLE/DONE/ERROR -> REQ when start_detecting = 1. On that transition: latch bus_addr, set = 0, clear done_processing and error. seven_seg keeps its last value.
  - REQ: bus_req = 1 for exactly one cycle; coef_select = set. Next state LOAD.
  - LOAD: bus_ready = 1. A word is accepted when bus_valid && bus_ready.
    - One cycle after acceptance: buf_we = 1, buf_sel = set, buf_addr = word count, buf_wdata = word. Write latency is exactly 1 cycle.
    - Word count increments on each accept.
    - Accepted word with bus_last = 1 and count = N-1: set complete. If set < NUM_LAYERS, set += 1 and go to REQ; otherwise go to RUN.
    - bus_last = 1 with count != N-1, or count = N-1 with bus_last = 0: go to ERROR. The offending word is not written.
  - RUN: ann_start = 1 for one cycle. Next state WAIT.
  - WAIT: on ann_done, register ann_class into the seven_seg decode and go to DONE. Pulses are not queued; any ann_done seen outside WAIT is ignored.
  - DONE: done_processing = 1, held until the next start.
  - ERROR: error = 1, seven_seg = 8'h86 ("E"), held until the next start.
- coef_select holds its value from REQ through the end of LOAD.
- bus_ready = 0 in every state except LOAD.
- start_detecting while busy is ignored.
- Bus stalls (bus_valid low) may last any length; no timeout unless the optional feature is enabled.
- n_reset assertion mid-load or mid-run returns the block to reset values immediately. No partial-set recovery.
- seven_seg decode of ann_class:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - 10..15 = BF (dash).

Optional Feature:
- ANN_LOADER_TIMEOUT_EN, when defined:
  - A watchdog counter resets on each state change and on each accepted word.
  - It counts cycles in LOAD and WAIT.
  - Reaching TIMEOUT_CYCLES forces ERROR; the dropped set is not written further.
- When not defined: no counter is synthesised, and LOAD/WAIT wait indefinitely.

Test Plan:
All scenarios use IMAGE_SIZE=4, LAYER_SIZE=2, NUM_LAYERS=2.
1. Reset release -> seven_seg = FF; busy, error, done_processing, bus_ready all 0.
2. Full nominal load:
   - Stimulus: start; stream 4 image words, 8 layer-0 words, 4 layer-1 words, each set with bus_last on its final word; then ann_done with ann_class = 3.
   - Response: three bus_req pulses with coef_select 0, 1, 2; buf_we count 4/8/4 with buf_addr 0..N-1; one ann_start; seven_seg = B0; done_processing = 1.
3. Image set with bus_last on word index 2 -> ERROR; error = 1; seven_seg = 86; only 2 buffer writes.
4. bus_valid toggled every other cycle during layer-0 load -> all 8 words written in order; no duplicate writes; one write per accepted word.
5. n_reset pulsed during layer-0 LOAD -> all outputs return to reset values. A subsequent start reloads from set 0 and completes with ann_class = 12 -> seven_seg = BF.
6. With ANN_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 16:
   - ann_done withheld in WAIT -> ERROR after 16 cycles.
   - start_detecting asserted during busy -> ignored.
